// File: rtl/axil2lb_pkg.sv
// Shared types and constants for the AXI4-Lite to local-bus bridge.
//   RESP_W       width of the AXI-Lite BRESP/RRESP fields
//   RESP_OKAY    normal completion
//   RESP_SLVERR  local-bus access timed out
//   wr_state_t   write-path FSM states
//   rd_state_t   read-path FSM states
package axil2lb_pkg;

  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_LB   = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_LB   = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

endpackage

// File: rtl/axil2lb_if.sv
// AXI4-Lite bus bundle between an AXI-Lite master and the bridge.
//   AW channel: awaddr, awprot, awvalid -> / <- awready
//   W  channel: wdata, wstrb, wvalid    -> / <- wready
//   B  channel: <- bresp, bvalid        / bready ->
//   AR channel: araddr, arprot, arvalid -> / <- arready
//   R  channel: <- rdata, rresp, rvalid / rready ->
// Modports: master (bus driver), slave (bridge side).
interface axil2lb_if
  import axil2lb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) ();

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [RESP_W-1:0] bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [RESP_W-1:0] rresp;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );

endinterface

// File: rtl/axil2lb_timeout.sv
// Cycle counter that flags a local-bus access which has waited too long.
//   clk, rst  clock, synchronous active-high reset
//   run       access in progress; counter is held at 0 while low
//   done      local bus answered this cycle; suppresses expiry
//   expired   last allowed cycle passed without an answer (TIMEOUT=0: never)
module axil2lb_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic done,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Cleared whenever idle, so every new access starts counting from 0.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Combinational so the owning FSM leaves on exactly the TIMEOUT-th cycle.
  assign expired = (TIMEOUT != 0) && run && !done && (cnt == LAST);

endmodule

// File: rtl/axil2lb_bridge.sv
// AXI4-Lite slave that turns each transaction into one local-bus access.
//   clk, rst     clock, synchronous active-high reset
//   axil         AXI-Lite slave bundle (PROT ignored)
//   lb_w*        write request: addr/data/strb with lb_wen held until lb_wready
//   lb_r*        read request: lb_raddr with lb_ren held until lb_rvalid/lb_rdata
// Read and write paths run independently; each has its own timeout.
module axil2lb_bridge
  import axil2lb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned STRB_W  = DATA_W / 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  axil2lb_if.slave          axil,
  output logic [ADDR_W-1:0] lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic [STRB_W-1:0] lb_wstrb,
  output logic              lb_wen,
  input  logic              lb_wready,
  output logic [ADDR_W-1:0] lb_raddr,
  output logic              lb_ren,
  input  logic [DATA_W-1:0] lb_rdata,
  input  logic              lb_rvalid
);

  wr_state_t         w_state, w_state_nxt;
  rd_state_t         r_state, r_state_nxt;
  logic              aw_held, aw_held_nxt, w_held, w_held_nxt;
  logic              awready_q, wready_q, bvalid_q;
  logic              arready_q, rvalid_q;
  logic [RESP_W-1:0] bresp_q, bresp_nxt, rresp_q, rresp_nxt;
  logic [DATA_W-1:0] rdata_q, rdata_nxt;
  logic              aw_hs, w_hs, ar_hs;
  logic              w_expired, r_expired;
  logic              unused_prot;

  assign unused_prot  = ^{axil.awprot, axil.arprot};

  assign axil.awready = awready_q;
  assign axil.wready  = wready_q;
  assign axil.bvalid  = bvalid_q;
  assign axil.bresp   = bresp_q;
  assign axil.arready = arready_q;
  assign axil.rvalid  = rvalid_q;
  assign axil.rresp   = rresp_q;
  assign axil.rdata   = rdata_q;

  // READYs are only ever high in the idle state, so these are true handshakes.
  assign aw_hs = axil.awvalid && awready_q;
  assign w_hs  = axil.wvalid  && wready_q;
  assign ar_hs = axil.arvalid && arready_q;

  axil2lb_timeout #(.TIMEOUT(TIMEOUT)) u_wr_timeout (
    .clk     (clk),
    .rst     (rst),
    .run     (w_state == W_LB),
    .done    (lb_wready),
    .expired (w_expired)
  );

  axil2lb_timeout #(.TIMEOUT(TIMEOUT)) u_rd_timeout (
    .clk     (clk),
    .rst     (rst),
    .run     (r_state == R_LB),
    .done    (lb_rvalid),
    .expired (r_expired)
  );

  // Write path next state: collect AW and W in any order, then one lb write.
  always_comb begin
    w_state_nxt = w_state;
    aw_held_nxt = aw_held;
    w_held_nxt  = w_held;
    bresp_nxt   = bresp_q;
    case (w_state)
      W_IDLE: begin
        if (aw_hs) aw_held_nxt = 1'b1;
        if (w_hs)  w_held_nxt  = 1'b1;
        if (aw_held_nxt && w_held_nxt) w_state_nxt = W_LB;
      end
      W_LB: begin
        // An answer on the final cycle beats the timeout.
        if (lb_wready) begin
          w_state_nxt = W_RESP;
          bresp_nxt   = RESP_OKAY;
        end else if (w_expired) begin
          w_state_nxt = W_RESP;
          bresp_nxt   = RESP_SLVERR;
        end
      end
      W_RESP: begin
        if (axil.bready) begin
          w_state_nxt = W_IDLE;
          aw_held_nxt = 1'b0;
          w_held_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write path registers; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      lb_wen    <= 1'b0;
      lb_waddr  <= '0;
      lb_wdata  <= '0;
      lb_wstrb  <= '0;
    end else begin
      w_state   <= w_state_nxt;
      aw_held   <= aw_held_nxt;
      w_held    <= w_held_nxt;
      awready_q <= (w_state_nxt == W_IDLE) && !aw_held_nxt;
      wready_q  <= (w_state_nxt == W_IDLE) && !w_held_nxt;
      bvalid_q  <= (w_state_nxt == W_RESP);
      bresp_q   <= bresp_nxt;
      lb_wen    <= (w_state_nxt == W_LB);
      if (aw_hs) lb_waddr <= axil.awaddr;
      if (w_hs) begin
        lb_wdata <= axil.wdata;
        lb_wstrb <= axil.wstrb;
      end
    end
  end

  // Read path next state: one lb read per AR, data captured on completion.
  always_comb begin
    r_state_nxt = r_state;
    rresp_nxt   = rresp_q;
    rdata_nxt   = rdata_q;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) r_state_nxt = R_LB;
      end
      R_LB: begin
        if (lb_rvalid) begin
          r_state_nxt = R_RESP;
          rdata_nxt   = lb_rdata;
          rresp_nxt   = RESP_OKAY;
        end else if (r_expired) begin
          r_state_nxt = R_RESP;
          rdata_nxt   = '0;
          rresp_nxt   = RESP_SLVERR;
        end
      end
      R_RESP: begin
        if (axil.rready) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read path registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      lb_ren    <= 1'b0;
      lb_raddr  <= '0;
    end else begin
      r_state   <= r_state_nxt;
      arready_q <= (r_state_nxt == R_IDLE);
      rvalid_q  <= (r_state_nxt == R_RESP);
      rresp_q   <= rresp_nxt;
      rdata_q   <= rdata_nxt;
      lb_ren    <= (r_state_nxt == R_LB);
      if (ar_hs) lb_raddr <= axil.araddr;
    end
  end

endmodule

// File: tb/tb_axil2lb_bridge.sv
// Self-checking bench for axil2lb_bridge: AXI-Lite master tasks, a behavioural
// local-bus slave with programmable latency, and scoreboard queues of
// expected lb writes and B/R responses.
module tb_axil2lb_bridge;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int          BUDGET  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil2lb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axil ();

  logic [ADDR_W-1:0] lb_waddr, lb_raddr;
  logic [DATA_W-1:0] lb_wdata;
  logic [STRB_W-1:0] lb_wstrb;
  logic              lb_wen, lb_ren;
  logic              lb_wready = 1'b0;
  logic              lb_rvalid = 1'b0;
  logic [DATA_W-1:0] lb_rdata  = '0;

  axil2lb_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .axil      (axil.slave),
    .lb_waddr  (lb_waddr),
    .lb_wdata  (lb_wdata),
    .lb_wstrb  (lb_wstrb),
    .lb_wen    (lb_wen),
    .lb_wready (lb_wready),
    .lb_raddr  (lb_raddr),
    .lb_ren    (lb_ren),
    .lb_rdata  (lb_rdata),
    .lb_rvalid (lb_rvalid)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } lbw_t;

  lbw_t        exp_lbw[$];
  lbw_t        act_lbw[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  int checks = 0;
  int errors = 0;

  // lb slave: answer on cycle (lat+1) of a request; lat < 0 never answers
  int          wr_lat = 0, rd_lat = 0;
  logic [31:0] rd_value = '0;
  int          wen_run = 0, ren_run = 0;
  int          wen_total = 0, ren_total = 0, overlap_total = 0;
  logic [15:0] raddr_seen = '0;

  wire [110:0] all_outs = {axil.awready, axil.wready, axil.bvalid, axil.bresp,
                           axil.arready, axil.rvalid, axil.rresp, axil.rdata,
                           lb_wen, lb_ren, lb_waddr, lb_wdata, lb_wstrb, lb_raddr};

  always @(negedge clk) begin
    if (lb_wen) begin
      wen_run++;
      wen_total++;
      lb_wready = (wr_lat >= 0) && (wen_run == wr_lat + 1);
      if (lb_wready) act_lbw.push_back({lb_waddr, lb_wdata, lb_wstrb});
    end else begin
      wen_run   = 0;
      lb_wready = 1'b0;
    end
    if (lb_ren) begin
      ren_run++;
      ren_total++;
      lb_rvalid = (rd_lat >= 0) && (ren_run == rd_lat + 1);
      if (lb_rvalid) raddr_seen = lb_raddr;
    end else begin
      ren_run   = 0;
      lb_rvalid = 1'b0;
    end
    lb_rdata = lb_rvalid ? rd_value : 32'hFFFF_FFFF;
    if (lb_wen && lb_ren) overlap_total++;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_aw(input logic [15:0] a);
    logic rdy;
    int   n;
    axil.awaddr = a; axil.awprot = 3'b000; axil.awvalid = 1'b1; n = 0;
    do begin
      @(negedge clk); rdy = axil.awready; cycle(); n++;
    end while (!rdy && n < BUDGET);
    axil.awvalid = 1'b0;
    checks++;
    if (!rdy) begin errors++; $display("FAIL aw_handshake: awready=%b after %0d cycles, required 1", rdy, n); end
  endtask

  task automatic axi_w(input logic [31:0] d, input logic [3:0] s);
    logic rdy;
    int   n;
    axil.wdata = d; axil.wstrb = s; axil.wvalid = 1'b1; n = 0;
    do begin
      @(negedge clk); rdy = axil.wready; cycle(); n++;
    end while (!rdy && n < BUDGET);
    axil.wvalid = 1'b0;
    checks++;
    if (!rdy) begin errors++; $display("FAIL w_handshake: wready=%b after %0d cycles, required 1", rdy, n); end
  endtask

  task automatic axi_ar(input logic [15:0] a);
    logic rdy;
    int   n;
    axil.araddr = a; axil.arprot = 3'b000; axil.arvalid = 1'b1; n = 0;
    do begin
      @(negedge clk); rdy = axil.arready; cycle(); n++;
    end while (!rdy && n < BUDGET);
    axil.arvalid = 1'b0;
    checks++;
    if (!rdy) begin errors++; $display("FAIL ar_handshake: arready=%b after %0d cycles, required 1", rdy, n); end
  endtask

  // Wait for BVALID, keep BREADY low rdy_delay cycles, then complete.
  task automatic get_b(input int rdy_delay, output logic [1:0] resp, output bit aw_seen);
    int n = 0;
    aw_seen = 1'b0;
    do begin
      @(negedge clk); n++;
      if (axil.awready) aw_seen = 1'b1;
    end while (!axil.bvalid && n < BUDGET);
    checks++;
    if (!axil.bvalid) begin errors++; $display("FAIL b_wait: bvalid=%b after %0d cycles, required 1", axil.bvalid, n); end
    repeat (rdy_delay) begin
      @(negedge clk);
      if (axil.awready) aw_seen = 1'b1;
    end
    resp = axil.bresp;
    axil.bready = 1'b1;
    cycle();
    axil.bready = 1'b0;
  endtask

  // Wait for RVALID, hold RREADY low rdy_delay cycles watching for changes.
  task automatic get_r(input int rdy_delay, output logic [31:0] d, output logic [1:0] r,
                       output bit stable);
    int n = 0;
    stable = 1'b1;
    do begin
      @(negedge clk); n++;
    end while (!axil.rvalid && n < BUDGET);
    checks++;
    if (!axil.rvalid) begin errors++; $display("FAIL r_wait: rvalid=%b after %0d cycles, required 1", axil.rvalid, n); end
    d = axil.rdata;
    r = axil.rresp;
    repeat (rdy_delay) begin
      @(negedge clk);
      if (axil.rvalid !== 1'b1 || axil.rdata !== d || axil.rresp !== r) stable = 1'b0;
    end
    axil.rready = 1'b1;
    cycle();
    axil.rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h, required 0", all_outs); end
    rst = 1'b0;
    cycle();
    checks++;
    if ({axil.awready, axil.wready, axil.arready} !== 3'b111) begin
      errors++; $display("FAIL idle_readys: got %b, required 111", {axil.awready, axil.wready, axil.arready});
    end
  endtask

  task automatic test_write_basic();
    logic [1:0] resp, eb;
    bit aws;
    lbw_t e, a;
    int w0;
    wr_lat = 1; w0 = wen_total;
    exp_b.push_back(2'b00);
    exp_lbw.push_back({16'h0004, 32'hDEADBEEF, 4'hF});
    fork
      axi_aw(16'h0004);
      axi_w(32'hDEADBEEF, 4'hF);
    join
    get_b(0, resp, aws);
    eb = exp_b.pop_front();
    checks++;
    if (resp !== eb) begin errors++; $display("FAIL wr_bresp: got %b, required %b", resp, eb); end
    checks++;
    if (act_lbw.size() != 1) begin errors++; $display("FAIL wr_lb_count: got %0d, required 1", act_lbw.size()); end
    if (act_lbw.size() > 0) begin
      a = act_lbw.pop_front(); e = exp_lbw.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL wr_lb_payload: got %h, required %h", a, e); end
    end
    checks++;
    if (wen_total - w0 != 2) begin errors++; $display("FAIL wr_wen_cycles: got %0d, required 2", wen_total - w0); end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp, eb;
    bit aws;
    lbw_t e, a;
    int w0;
    wr_lat = 0; w0 = wen_total;
    exp_b.push_back(2'b00);
    exp_lbw.push_back({16'h0010, 32'h0BADCAFE, 4'b1100});
    axi_w(32'h0BADCAFE, 4'b1100);
    repeat (3) cycle();
    checks++;
    if (lb_wen !== 1'b0 || wen_total != w0) begin
      errors++; $display("FAIL early_lb_write: lb_wen=%b cycles=%0d, required 0/0", lb_wen, wen_total - w0);
    end
    checks++;
    if ({axil.wready, axil.awready} !== 2'b01) begin
      errors++; $display("FAIL w_held_readys: wready/awready=%b, required 01", {axil.wready, axil.awready});
    end
    axi_aw(16'h0010);
    get_b(0, resp, aws);
    eb = exp_b.pop_front();
    checks++;
    if (resp !== eb) begin errors++; $display("FAIL wfirst_bresp: got %b, required %b", resp, eb); end
    checks++;
    if (act_lbw.size() != 1) begin errors++; $display("FAIL wfirst_lb_count: got %0d, required 1", act_lbw.size()); end
    if (act_lbw.size() > 0) begin
      a = act_lbw.pop_front(); e = exp_lbw.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL wfirst_lb_payload: got %h, required %h", a, e); end
    end
  endtask

  task automatic test_read_basic();
    logic [31:0] d;
    logic [1:0]  r;
    logic [33:0] er;
    bit st;
    int r0;
    rd_lat = 4; rd_value = 32'h12345678; r0 = ren_total;
    exp_r.push_back({2'b00, 32'h12345678});
    axi_ar(16'h0008);
    get_r(3, d, r, st);
    er = exp_r.pop_front();
    checks++;
    if ({r, d} !== er) begin errors++; $display("FAIL rd_resp_data: got %h, required %h", {r, d}, er); end
    checks++;
    if (!st) begin errors++; $display("FAIL rd_stable: stable=%b, required 1", st); end
    checks++;
    if (ren_total - r0 != 5) begin errors++; $display("FAIL rd_ren_cycles: got %0d, required 5", ren_total - r0); end
    checks++;
    if (raddr_seen !== 16'h0008) begin errors++; $display("FAIL rd_lb_addr: got %h, required 0008", raddr_seen); end
  endtask

  task automatic test_timeout();
    logic [1:0]  resp, eb, r;
    logic [31:0] d;
    logic [33:0] er;
    bit aws, st;
    lbw_t e, a;
    int w0, r0;
    wr_lat = -1; rd_lat = -1; w0 = wen_total; r0 = ren_total;
    exp_b.push_back(2'b10);
    exp_r.push_back({2'b10, 32'h0});
    fork
      axi_aw(16'h0030);
      axi_w(32'h11112222, 4'hF);
      axi_ar(16'h0034);
    join
    fork
      get_b(0, resp, aws);
      get_r(0, d, r, st);
    join
    eb = exp_b.pop_front(); er = exp_r.pop_front();
    checks++;
    if (resp !== eb) begin errors++; $display("FAIL to_bresp: got %b, required %b", resp, eb); end
    checks++;
    if ({r, d} !== er) begin errors++; $display("FAIL to_rresp_data: got %h, required %h", {r, d}, er); end
    checks++;
    if (wen_total - w0 != int'(TIMEOUT)) begin errors++; $display("FAIL to_wen_cycles: got %0d, required %0d", wen_total - w0, TIMEOUT); end
    checks++;
    if (ren_total - r0 != int'(TIMEOUT)) begin errors++; $display("FAIL to_ren_cycles: got %0d, required %0d", ren_total - r0, TIMEOUT); end
    checks++;
    if (act_lbw.size() != 0) begin errors++; $display("FAIL to_lb_writes: got %0d, required 0", act_lbw.size()); end
    // recovery: next accesses complete normally
    wr_lat = 0; rd_lat = 0; rd_value = 32'h5A5AC3C3;
    exp_b.push_back(2'b00);
    exp_r.push_back({2'b00, 32'h5A5AC3C3});
    exp_lbw.push_back({16'h0038, 32'h33334444, 4'hF});
    fork
      axi_aw(16'h0038);
      axi_w(32'h33334444, 4'hF);
      axi_ar(16'h003C);
    join
    fork
      get_b(0, resp, aws);
      get_r(0, d, r, st);
    join
    eb = exp_b.pop_front(); er = exp_r.pop_front();
    checks++;
    if (resp !== eb) begin errors++; $display("FAIL rec_bresp: got %b, required %b", resp, eb); end
    checks++;
    if ({r, d} !== er) begin errors++; $display("FAIL rec_rresp_data: got %h, required %h", {r, d}, er); end
    if (act_lbw.size() > 0) begin
      a = act_lbw.pop_front(); e = exp_lbw.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL rec_lb_payload: got %h, required %h", a, e); end
    end
  endtask

  task automatic test_concurrent();
    logic [1:0]  resp, eb, r;
    logic [31:0] d;
    logic [33:0] er;
    logic aw_after;
    bit aws, st;
    lbw_t e, a;
    int ov0;
    wr_lat = 2; rd_lat = 2; rd_value = 32'hCAFEF00D; ov0 = overlap_total;
    exp_b.push_back(2'b00);
    exp_r.push_back({2'b00, 32'hCAFEF00D});
    exp_lbw.push_back({16'h0020, 32'hA5A55A5A, 4'b0101});
    fork
      axi_aw(16'h0020);
      axi_w(32'hA5A55A5A, 4'b0101);
      axi_ar(16'h0024);
    join
    fork
      begin
        get_b(4, resp, aws);
        aw_after = axil.awready;
      end
      get_r(0, d, r, st);
    join
    eb = exp_b.pop_front(); er = exp_r.pop_front();
    checks++;
    if (resp !== eb) begin errors++; $display("FAIL cc_bresp: got %b, required %b", resp, eb); end
    checks++;
    if ({r, d} !== er) begin errors++; $display("FAIL cc_rresp_data: got %h, required %h", {r, d}, er); end
    checks++;
    if (overlap_total - ov0 < 1) begin errors++; $display("FAIL cc_overlap: got %0d cycles, required >0", overlap_total - ov0); end
    checks++;
    if (aws || aw_after !== 1'b1) begin
      errors++; $display("FAIL cc_awready: during B=%b after B=%b, required 0/1", aws, aw_after);
    end
    checks++;
    if (raddr_seen !== 16'h0024) begin errors++; $display("FAIL cc_lb_raddr: got %h, required 0024", raddr_seen); end
    if (act_lbw.size() > 0) begin
      a = act_lbw.pop_front(); e = exp_lbw.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL cc_lb_payload: got %h, required %h", a, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp, eb;
    bit aws;
    lbw_t e, a;
    int spurious;
    wr_lat = -1; rd_lat = -1; spurious = 0;
    fork
      axi_aw(16'h0040);
      axi_w(32'h77778888, 4'hF);
      axi_ar(16'h0044);
    join
    repeat (2) cycle();
    checks++;
    if ({lb_wen, lb_ren} !== 2'b11) begin errors++; $display("FAIL mid_inflight: wen/ren=%b, required 11", {lb_wen, lb_ren}); end
    rst = 1'b1;
    cycle();
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h, required 0", all_outs); end
    rst = 1'b0;
    repeat (12) begin
      cycle();
      if (axil.bvalid || axil.rvalid || lb_wen || lb_ren) spurious++;
    end
    checks++;
    if (spurious != 0) begin errors++; $display("FAIL mid_no_response: got %0d active cycles, required 0", spurious); end
    wr_lat = 0;
    exp_b.push_back(2'b00);
    exp_lbw.push_back({16'h0050, 32'h9ABCDEF0, 4'b0011});
    fork
      axi_aw(16'h0050);
      axi_w(32'h9ABCDEF0, 4'b0011);
    join
    get_b(0, resp, aws);
    eb = exp_b.pop_front();
    checks++;
    if (resp !== eb) begin errors++; $display("FAIL post_reset_bresp: got %b, required %b", resp, eb); end
    if (act_lbw.size() > 0) begin
      a = act_lbw.pop_front(); e = exp_lbw.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL post_reset_lb_payload: got %h, required %h", a, e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b0;
    axil.wdata  = '0; axil.wstrb  = '0; axil.wvalid  = 1'b0;
    axil.bready = 1'b0;
    axil.araddr = '0; axil.arprot = '0; axil.arvalid = 1'b0;
    axil.rready = 1'b0;

    test_reset();
    test_write_basic();
    test_w_before_aw();
    test_read_basic();
    test_timeout();
    test_concurrent();
    test_reset_mid();

    checks++;
    if (exp_b.size() + exp_r.size() + exp_lbw.size() + act_lbw.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: b=%0d r=%0d lbw_exp=%0d lbw_act=%0d, required all 0",
               exp_b.size(), exp_r.size(), exp_lbw.size(), act_lbw.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
